// File: rtl/piradip_axi4mmlite_arbiter.sv
// -----------------------------------------------------------------------------
// piradip_axi4mmlite_arbiter
//   Round-robin arbiter that funnels NUM_REQ simple request ports onto a single
//   AXI4-Lite manager. Exactly one AXI transaction is in flight at a time.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   req_valid/req_write  per-requester request present / 1=write 0=read
//   req_addr/wdata/wstrb packed per-requester payload, requester i at [i*W +: W]
//   req_ready            combinational one-cycle accept pulse (IDLE only)
//   rsp_valid            registered one-cycle completion pulse to the owner
//   rsp_rdata/rsp_resp   shared completion payload (rdata is 0 for writes)
//   busy                 a transaction is in flight
//   m_aw*/m_w*/m_b*/m_ar*/m_r*  AXI4-Lite manager interface, outputs registered
// -----------------------------------------------------------------------------
module piradip_axi4mmlite_arbiter #(
   parameter int  NUM_REQ    = 2,
   parameter int  ADDR_WIDTH = 8,
   parameter int  DATA_WIDTH = 32,
   localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   // requester side
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ-1:0]              req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
   input  logic [NUM_REQ*STRB_WIDTH-1:0]   req_wstrb,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [NUM_REQ-1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]           rsp_rdata,
   output logic [1:0]                      rsp_resp,
   output logic                            busy,
   // AXI4-Lite manager
   output logic [ADDR_WIDTH-1:0]           m_awaddr,
   output logic [2:0]                      m_awprot,
   output logic                            m_awvalid,
   input  logic                            m_awready,
   output logic [DATA_WIDTH-1:0]           m_wdata,
   output logic [STRB_WIDTH-1:0]           m_wstrb,
   output logic                            m_wvalid,
   input  logic                            m_wready,
   input  logic [1:0]                      m_bresp,
   input  logic                            m_bvalid,
   output logic                            m_bready,
   output logic [ADDR_WIDTH-1:0]           m_araddr,
   output logic [2:0]                      m_arprot,
   output logic                            m_arvalid,
   input  logic                            m_arready,
   input  logic [DATA_WIDTH-1:0]           m_rdata,
   input  logic [1:0]                      m_rresp,
   input  logic                            m_rvalid,
   output logic                            m_rready
);
   localparam int IDXW = $clog2(NUM_REQ);

   typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RRESP} state_t;

   // request captured at accept; drives the AXI address/data outputs directly
   typedef struct packed {
      logic [IDXW-1:0]       owner;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [STRB_WIDTH-1:0] wstrb;
   } lat_t;

   state_t          state, state_nxt;
   lat_t            lat;
   logic [IDXW-1:0] rr_ptr;
   logic [IDXW-1:0] grant, scan_idx;
   logic            grant_vld;
   logic            aw_pend, w_pend;

   assign busy     = (state != IDLE);
   assign m_awprot = 3'b000;
   assign m_arprot = 3'b000;
   assign m_awaddr = lat.addr;
   assign m_araddr = lat.addr;
   assign m_wdata  = lat.wdata;
   assign m_wstrb  = lat.wstrb;

   // scan starts one past the last winner so every requester gets a turn
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      scan_idx  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = IDXW'((int'(rr_ptr) + k) % NUM_REQ);
         if (!grant_vld && req_valid[scan_idx]) begin
            grant     = scan_idx;
            grant_vld = 1'b1;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && grant_vld) req_ready[grant] = 1'b1;
   end

   // AW and W still outstanding after this cycle's edge
   assign aw_pend = m_awvalid & ~m_awready;
   assign w_pend  = m_wvalid  & ~m_wready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_vld) state_nxt = req_write[grant] ? WADDR : RADDR;
         WADDR:   if (!aw_pend && !w_pend) state_nxt = WRESP;
         WRESP:   if (m_bvalid) state_nxt = IDLE;
         RADDR:   if (m_arready) state_nxt = RRESP;
         RRESP:   if (m_rvalid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rr_ptr    <= IDXW'(NUM_REQ - 1);
         lat       <= '0;
         m_awvalid <= 1'b0;
         m_wvalid  <= 1'b0;
         m_bready  <= 1'b0;
         m_arvalid <= 1'b0;
         m_rready  <= 1'b0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_resp  <= 2'b00;
      end else begin
         rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  rr_ptr    <= grant;
                  lat.owner <= grant;
                  lat.addr  <= req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
                  lat.wdata <= req_wdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
                  lat.wstrb <= req_wstrb[int'(grant)*STRB_WIDTH +: STRB_WIDTH];
                  m_awvalid <= req_write[grant];
                  m_wvalid  <= req_write[grant];
                  m_arvalid <= ~req_write[grant];
               end
            end
            WADDR: begin
               // AW and W retire independently, in either order
               if (m_awready) m_awvalid <= 1'b0;
               if (m_wready)  m_wvalid  <= 1'b0;
               if (!aw_pend && !w_pend) m_bready <= 1'b1;
            end
            WRESP: begin
               if (m_bvalid) begin
                  m_bready             <= 1'b0;
                  rsp_valid[lat.owner] <= 1'b1;
                  rsp_rdata            <= '0;
                  rsp_resp             <= m_bresp;
               end
            end
            RADDR: begin
               if (m_arready) begin
                  m_arvalid <= 1'b0;
                  m_rready  <= 1'b1;
               end
            end
            RRESP: begin
               if (m_rvalid) begin
                  m_rready             <= 1'b0;
                  rsp_valid[lat.owner] <= 1'b1;
                  rsp_rdata            <= m_rdata;
                  rsp_resp             <= m_rresp;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_piradip_axi4mmlite_arbiter.sv
// -----------------------------------------------------------------------------
// tb_piradip_axi4mmlite_arbiter
//   Cycle-stepped bench: requesters and an AXI4-Lite subordinate with
//   programmable wait states are modelled in tasks. Accepted requests push an
//   expected completion into a scoreboard that is popped on rsp_valid.
// -----------------------------------------------------------------------------
module tb_piradip_axi4mmlite_arbiter;
   localparam int NR = 2;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int IW = $clog2(NR);

   logic              aclk = 1'b0;
   logic              aresetn = 1'b1;
   logic [NR-1:0]     req_valid = '0, req_write = '0, req_ready, rsp_valid;
   logic [NR*AW-1:0]  req_addr = '0;
   logic [NR*DW-1:0]  req_wdata = '0;
   logic [NR*SW-1:0]  req_wstrb = '0;
   logic [DW-1:0]     rsp_rdata;
   logic [1:0]        rsp_resp;
   logic              busy;
   logic [AW-1:0]     m_awaddr, m_araddr;
   logic [2:0]        m_awprot, m_arprot;
   logic              m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
   logic [DW-1:0]     m_wdata;
   logic [SW-1:0]     m_wstrb;
   logic              m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
   logic              m_arready = 1'b0, m_rvalid = 1'b0;
   logic [1:0]        m_bresp = 2'b00, m_rresp = 2'b00;
   logic [DW-1:0]     m_rdata = '0;

   always #5 aclk = ~aclk;

   piradip_axi4mmlite_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
      .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   typedef struct {
      int            owner;
      bit            write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
   } req_t;

   typedef struct {
      int            owner;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
      logic [DW-1:0] rdata;
      logic [1:0]    resp;
   } exp_t;

   req_t pend[$];
   exp_t sb[$];
   int   grant_log[$];
   req_t cur[NR];
   bit   cur_vld[NR];
   bit   acc[NR];

   int total = 0, bad = 0, cyc = 0;
   int rr = NR - 1;
   int rsp_count = 0, acc_cyc = 0, rsp_cyc = 0, b2b_cnt = 0;
   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
   logic [DW-1:0] cfg_rdata = '0;
   logic [1:0]    cfg_resp = 2'b00;
   logic [NR-1:0] last_rsp_vec = '0;
   logic [DW-1:0] last_rdata = '0;
   logic [1:0]    last_resp = 2'b00;

   bit            prev_ok = 0;
   logic          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
   logic [AW-1:0] p_awaddr, p_araddr;
   logic [DW-1:0] p_wdata;
   logic [SW-1:0] p_wstrb;

   function automatic req_t mk_req(int o, bit w, logic [AW-1:0] a, logic [DW-1:0] d,
                                   logic [SW-1:0] s);
      req_t r;
      r.owner = o; r.write = w; r.addr = a; r.wdata = d; r.wstrb = s;
      return r;
   endfunction

   function automatic bit idle_now();
      bit any = 0;
      for (int i = 0; i < NR; i++) any |= cur_vld[i];
      return (pend.size() == 0) && !any && (sb.size() == 0) && !busy;
   endfunction

   task automatic drive_sub();
      m_awready = m_awvalid && (aw_cnt >= aw_dly);
      m_wready  = m_wvalid  && (w_cnt  >= w_dly);
      m_arready = m_arvalid && (ar_cnt >= ar_dly);
      m_bvalid  = m_bready  && (b_cnt  >= b_dly);
      m_rvalid  = m_rready  && (r_cnt  >= r_dly);
      m_bresp   = cfg_resp;
      m_rresp   = cfg_resp;
      m_rdata   = cfg_rdata;
   endtask

   // mid-cycle sampling: scoreboard, grant model, handshake payload, stability
   task automatic observe();
      bit            rsp_now = 0;
      exp_t          e;
      int            g;
      logic [NR-1:0] t;
      if (rsp_valid !== '0) begin
         rsp_now = 1; rsp_count++; rsp_cyc = cyc;
         last_rsp_vec = rsp_valid; last_rdata = rsp_rdata; last_resp = rsp_resp;
         total++;
         if (sb.size() == 0) begin
            bad++; $display("FAIL stale_rsp: rsp_valid=%b with nothing outstanding", rsp_valid);
         end else begin
            e = sb.pop_front();
            total++;
            if (rsp_valid !== (NR'(1) << e.owner) || rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
               bad++;
               $display("FAIL rsp_payload: got vec=%b rdata=%h resp=%b, want vec=%b rdata=%h resp=%b",
                        rsp_valid, rsp_rdata, rsp_resp, NR'(1) << e.owner, e.rdata, e.resp);
            end
         end
      end
      if (req_ready !== '0 || (!busy && req_valid !== '0)) begin
         g = -1;
         for (int k = 1; k <= NR; k++) begin
            t = req_valid >> ((rr + k) % NR);
            if (g < 0 && t[0]) g = (rr + k) % NR;
         end
         total++;
         if (g < 0 || req_ready !== (NR'(1) << g)) begin
            bad++;
            $display("FAIL grant: req_ready=%b req_valid=%b, want grant index %0d", req_ready, req_valid, g);
         end else begin
            e.owner = g; e.addr = cur[g].addr; e.wdata = cur[g].wdata; e.wstrb = cur[g].wstrb;
            e.rdata = cur[g].write ? '0 : cfg_rdata;
            e.resp  = cfg_resp;
            sb.push_back(e);
            acc[g] = 1; rr = g; grant_log.push_back(g); acc_cyc = cyc;
            if (rsp_now) b2b_cnt++;
         end
      end
      if (m_awvalid && m_awready) begin
         total++; aw_cnt = 0;
         if (sb.size() == 0) begin bad++; $display("FAIL aw_hs: no outstanding request"); end
         else if (m_awaddr !== sb[0].addr || m_awprot !== 3'b000) begin
            bad++; $display("FAIL aw_hs: awaddr=%h prot=%b, want %h 000", m_awaddr, m_awprot, sb[0].addr);
         end
      end else if (m_awvalid) aw_cnt++;
      if (m_wvalid && m_wready) begin
         total++; w_cnt = 0;
         if (sb.size() == 0) begin bad++; $display("FAIL w_hs: no outstanding request"); end
         else if (m_wdata !== sb[0].wdata || m_wstrb !== sb[0].wstrb) begin
            bad++; $display("FAIL w_hs: wdata=%h wstrb=%h, want %h %h", m_wdata, m_wstrb, sb[0].wdata, sb[0].wstrb);
         end
      end else if (m_wvalid) w_cnt++;
      if (m_arvalid && m_arready) begin
         total++; ar_cnt = 0;
         if (sb.size() == 0) begin bad++; $display("FAIL ar_hs: no outstanding request"); end
         else if (m_araddr !== sb[0].addr || m_arprot !== 3'b000) begin
            bad++; $display("FAIL ar_hs: araddr=%h prot=%b, want %h 000", m_araddr, m_arprot, sb[0].addr);
         end
      end else if (m_arvalid) ar_cnt++;
      if (m_bready && m_bvalid) b_cnt = 0; else if (m_bready) b_cnt++;
      if (m_rready && m_rvalid) r_cnt = 0; else if (m_rready) r_cnt++;
      if (prev_ok && p_awv && !p_awr) begin
         total++;
         if (m_awvalid !== 1'b1 || m_awaddr !== p_awaddr) begin
            bad++; $display("FAIL aw_stable: awvalid=%b awaddr=%h, want 1 %h", m_awvalid, m_awaddr, p_awaddr);
         end
      end
      if (prev_ok && p_wv && !p_wr) begin
         total++;
         if (m_wvalid !== 1'b1 || m_wdata !== p_wdata || m_wstrb !== p_wstrb) begin
            bad++; $display("FAIL w_stable: wvalid=%b wdata=%h, want 1 %h", m_wvalid, m_wdata, p_wdata);
         end
      end
      if (prev_ok && p_arv && !p_arr) begin
         total++;
         if (m_arvalid !== 1'b1 || m_araddr !== p_araddr) begin
            bad++; $display("FAIL ar_stable: arvalid=%b araddr=%h, want 1 %h", m_arvalid, m_araddr, p_araddr);
         end
      end
      p_awv = m_awvalid; p_awr = m_awready; p_awaddr = m_awaddr;
      p_wv = m_wvalid; p_wr = m_wready; p_wdata = m_wdata; p_wstrb = m_wstrb;
      p_arv = m_arvalid; p_arr = m_arready; p_araddr = m_araddr;
      prev_ok = 1;
   endtask

   task automatic sample();
      @(negedge aclk);
      observe();
   endtask

   task automatic advance();
      bit found;
      @(posedge aclk); #1; cyc++;
      for (int i = 0; i < NR; i++) begin
         if (acc[i]) cur_vld[i] = 0;
         acc[i] = 0;
      end
      for (int i = 0; i < NR; i++) begin
         found = 0;
         if (!cur_vld[i]) begin
            for (int k = 0; k < pend.size(); k++) begin
               if (!found && pend[k].owner == i) begin
                  cur[i] = pend[k]; pend.delete(k); cur_vld[i] = 1; found = 1;
               end
            end
         end
      end
      for (int i = 0; i < NR; i++) begin
         req_valid[IW'(i)]     = cur_vld[i];
         req_write[IW'(i)]     = cur[i].write;
         req_addr[i*AW +: AW]  = cur[i].addr;
         req_wdata[i*DW +: DW] = cur[i].wdata;
         req_wstrb[i*SW +: SW] = cur[i].wstrb;
      end
      drive_sub();
   endtask

   task automatic step();
      sample();
      advance();
   endtask

   task automatic run_until_idle(input int max, input string name);
      int n = 0;
      do begin step(); n++; end while (!idle_now() && n < max);
      total++;
      if (!idle_now()) begin
         bad++; $display("FAIL %s_timeout: still busy after %0d cycles, want idle", name, n);
      end
   endtask

   // asserts reset away from the clock edge, checks the immediate effect
   task automatic reset_pulse();
      req_valid = '0;
      #2 aresetn = 1'b0;
      #1;
      total++;
      if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0) begin
         bad++; $display("FAIL reset_axi: aw/w/ar/b/r=%b, want 00000",
                         {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready});
      end
      total++;
      if (busy !== 1'b0 || rsp_valid !== '0 || req_ready !== '0) begin
         bad++; $display("FAIL reset_status: busy=%b rsp_valid=%b req_ready=%b, want 0", busy, rsp_valid, req_ready);
      end
      total++;
      if (rsp_rdata !== '0 || rsp_resp !== 2'b00 || m_awaddr !== '0) begin
         bad++; $display("FAIL reset_payload: rdata=%h resp=%b awaddr=%h, want 0", rsp_rdata, rsp_resp, m_awaddr);
      end
      pend.delete(); sb.delete();
      for (int i = 0; i < NR; i++) begin cur_vld[i] = 0; acc[i] = 0; end
      rr = NR - 1; prev_ok = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      advance();
   endtask

   task automatic test_reset();
      @(negedge aclk);
      reset_pulse();
      repeat (3) step();
      total++;
      if (busy !== 1'b0 || rsp_count !== 0) begin
         bad++; $display("FAIL reset_idle: busy=%b rsp_count=%0d, want 0 0", busy, rsp_count);
      end
   endtask

   task automatic test_single_write();
      int n0;
      aw_dly = 0; w_dly = 0; b_dly = 0; cfg_resp = 2'b00; cfg_rdata = 32'hDEADBEEF;
      pend.push_back(mk_req(0, 1, 8'h10, 32'hA5A5A5A5, 4'hF));
      advance();
      sample();
      total++;
      if (req_ready !== 2'b01) begin bad++; $display("FAIL wr_accept_c0: req_ready=%b, want 01", req_ready); end
      advance(); sample();
      total++;
      if (m_awvalid !== 1'b1 || m_awaddr !== 8'h10 || m_wvalid !== 1'b1 || m_wdata !== 32'hA5A5A5A5) begin
         bad++; $display("FAIL wr_valid_c1: awvalid=%b awaddr=%h wvalid=%b wdata=%h, want 1 10 1 a5a5a5a5",
                         m_awvalid, m_awaddr, m_wvalid, m_wdata);
      end
      advance(); sample();
      total++;
      if (m_bready !== 1'b1 || busy !== 1'b1) begin
         bad++; $display("FAIL wr_bready_c2: bready=%b busy=%b, want 1 1", m_bready, busy);
      end
      n0 = rsp_count;
      advance(); sample();
      total++;
      if (rsp_valid !== 2'b01 || rsp_resp !== 2'b00 || rsp_rdata !== '0 || rsp_count != n0 + 1) begin
         bad++; $display("FAIL wr_rsp_c3: rsp_valid=%b resp=%b rdata=%h, want 01 00 0", rsp_valid, rsp_resp, rsp_rdata);
      end
      advance(); sample();
      total++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
         bad++; $display("FAIL wr_rsp_pulse: rsp_valid=%b busy=%b, want 00 0", rsp_valid, busy);
      end
      advance();
   endtask

   task automatic test_read_resp();
      int n0 = rsp_count;
      cfg_rdata = 32'h12345678; cfg_resp = 2'b10;
      pend.push_back(mk_req(1, 0, 8'h20, 32'h0, 4'h0));
      run_until_idle(40, "rd");
      total++;
      if (rsp_count != n0 + 1 || last_rsp_vec !== 2'b10 || last_rdata !== 32'h12345678 || last_resp !== 2'b10) begin
         bad++; $display("FAIL rd_rsp: count=%0d vec=%b rdata=%h resp=%b, want %0d 10 12345678 10",
                         rsp_count - n0, last_rsp_vec, last_rdata, last_resp, 1);
      end
      total++;
      if (rsp_cyc - acc_cyc != 3) begin
         bad++; $display("FAIL rd_latency: %0d cycles, want 3", rsp_cyc - acc_cyc);
      end
   endtask

   task automatic test_slow_write();
      int n0 = rsp_count;
      int n = 0;
      bit w_first = 0, aw_first = 0;
      aw_dly = 3; w_dly = 0; b_dly = 5; cfg_resp = 2'b00;
      pend.push_back(mk_req(0, 1, 8'h44, 32'h0BADF00D, 4'h5));
      advance();
      do begin
         sample();
         if (m_wvalid === 1'b0 && m_awvalid === 1'b1) w_first = 1;
         if (m_awvalid === 1'b0 && m_wvalid === 1'b1) aw_first = 1;
         advance(); n++;
      end while (!idle_now() && n < 40);
      total++;
      if (!idle_now()) begin bad++; $display("FAIL slow_timeout: busy after %0d cycles, want idle", n); end
      total++;
      if (w_first !== 1 || aw_first !== 0) begin
         bad++; $display("FAIL slow_order: w_first=%0d aw_first=%0d, want 1 0", w_first, aw_first);
      end
      total++;
      if (rsp_count != n0 + 1 || rsp_cyc - acc_cyc != 11) begin
         bad++; $display("FAIL slow_rsp: count=%0d latency=%0d, want 1 11", rsp_count - n0, rsp_cyc - acc_cyc);
      end
      aw_dly = 0; b_dly = 0;
   endtask

   task automatic test_round_robin();
      @(negedge aclk);
      reset_pulse();
      cfg_resp = 2'b11; cfg_rdata = 32'hCAFE0001;
      grant_log.delete(); b2b_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         pend.push_back(mk_req(0, (k % 2) == 0, 8'h80 + 8'(k), 32'h1000 + 32'(k), 4'hF));
         pend.push_back(mk_req(1, (k % 2) == 1, 8'hC0 + 8'(k), 32'h2000 + 32'(k), 4'h3));
      end
      run_until_idle(200, "rr");
      total++;
      if (grant_log.size() != 8) begin
         bad++; $display("FAIL rr_count: %0d grants, want 8", grant_log.size());
      end
      for (int i = 0; i < grant_log.size(); i++) begin
         total++;
         if (grant_log[i] != i % 2) begin
            bad++; $display("FAIL rr_order: grant %0d went to %0d, want %0d", i, grant_log[i], i % 2);
         end
      end
      total++;
      if (b2b_cnt != 7) begin bad++; $display("FAIL rr_b2b: %0d overlapped accepts, want 7", b2b_cnt); end
   endtask

   task automatic test_back_to_back();
      cfg_resp = 2'b01; cfg_rdata = 32'h00C0FFEE;
      grant_log.delete(); b2b_cnt = 0;
      pend.push_back(mk_req(0, 1, 8'h04, 32'h11111111, 4'h1));
      pend.push_back(mk_req(0, 0, 8'h08, 32'h0, 4'h0));
      pend.push_back(mk_req(0, 1, 8'h0C, 32'h33333333, 4'hC));
      run_until_idle(60, "b2b");
      total++;
      if (grant_log.size() != 3 || b2b_cnt != 2) begin
         bad++; $display("FAIL b2b_overlap: grants=%0d overlapped=%0d, want 3 2", grant_log.size(), b2b_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int n0;
      bit got = 0;
      b_dly = 10; cfg_resp = 2'b00;
      pend.push_back(mk_req(0, 1, 8'h30, 32'h55AA55AA, 4'hF));
      advance();
      do begin
         sample();
         got = (m_bready === 1'b1);
         if (!got) advance();
         n++;
      end while (!got && n < 20);
      total++;
      if (!got) begin bad++; $display("FAIL mid_reach_wresp: bready=%b, want 1", m_bready); end
      reset_pulse();
      b_dly = 0;
      n0 = rsp_count;
      repeat (6) step();
      total++;
      if (rsp_count != n0) begin bad++; $display("FAIL mid_stale: %0d responses, want 0", rsp_count - n0); end
      grant_log.delete();
      pend.push_back(mk_req(1, 0, 8'h50, 32'h0, 4'h0));
      pend.push_back(mk_req(0, 0, 8'h60, 32'h0, 4'h0));
      run_until_idle(60, "mid");
      total++;
      if (grant_log.size() == 0 || grant_log[0] != 0) begin
         bad++; $display("FAIL mid_first_grant: first grant=%0d, want 0",
                         grant_log.size() == 0 ? -1 : grant_log[0]);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_resp();
      test_slow_write();
      test_round_robin();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/piradip_axi4mmlite_arbiter.md
PIRADIP_AXI4MMLITE_ARBITER -- requirements
Module: piradip_axi4mmlite_arbiter

Interface
REQ-001 NUM_REQ, 2, number of requesters (legal 2..4).
REQ-002 ADDR_WIDTH, 8, AXI4-Lite address width.
REQ-003 DATA_WIDTH, 32, AXI4-Lite data width (32 or 64); STRB_WIDTH = DATA_WIDTH/8.
REQ-004 aclk  in  1  sole clock; one clock; all logic on rising edge.
REQ-005 aresetn  in  1  reset, asynchronous, active-low.
REQ-006 req_valid, req_write  in  NUM_REQ each  per-requester request present; 1=write, 0=read.
REQ-007 req_addr  in  NUM_REQ*ADDR_WIDTH  packed byte addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 req_wdata, req_wstrb  in  NUM_REQ*DATA_WIDTH, NUM_REQ*STRB_WIDTH  packed write data/strobes.
REQ-009 req_ready  out  NUM_REQ  one-cycle accept pulse to granted requester.
REQ-010 rsp_valid  out  NUM_REQ  one-cycle completion pulse to owning requester; no backpressure.
REQ-011 rsp_rdata, rsp_resp  out  DATA_WIDTH, 2  shared completion payload, valid only with rsp_valid.
REQ-012 busy  out  1  transaction in flight (state != IDLE).
REQ-013 m_aw*: m_awaddr/m_awprot/m_awvalid out ADDR_WIDTH/3/1, m_awready in 1.
REQ-014 m_w*: m_wdata/m_wstrb/m_wvalid out DATA_WIDTH/STRB_WIDTH/1, m_wready in 1.
REQ-015 m_b*: m_bresp in 2, m_bvalid in 1, m_bready out 1.
REQ-016 m_ar*: m_araddr/m_arprot/m_arvalid out ADDR_WIDTH/3/1, m_arready in 1.
REQ-017 m_r*: m_rdata/m_rresp/m_rvalid in DATA_WIDTH/2/1, m_rready out 1.

Function
REQ-018 States: IDLE, WADDR, WRESP, RADDR, RRESP; exactly one AXI4-Lite transaction outstanding.
REQ-019 Round-robin: rr_ptr = last granted index; grant = first i in order rr_ptr+1 .. rr_ptr (mod NUM_REQ) with req_valid[i]=1.
REQ-020 In IDLE with any req_valid: req_ready[grant]=1 that cycle (combinational), request latched, rr_ptr<=grant, next state WADDR or RADDR per req_write.
REQ-021 Requester holds req_* stable while req_valid=1 until req_ready; req_valid dropped before accept is legal and causes no grant.
REQ-022 WADDR: m_awvalid and m_wvalid both asserted from first cycle; each deasserts independently after its own handshake; AW and W handshakes may occur in any order or same cycle.
REQ-023 Both AW and W complete -> WRESP with m_bready=1; on m_bvalid: capture m_bresp, go IDLE.
REQ-024 RADDR: m_arvalid=1 until m_arready; then RRESP with m_rready=1; on m_rvalid capture m_rdata/m_rresp, go IDLE.
REQ-025 Completion: rsp_valid[owner]=1 for exactly the cycle after B/R handshake (registered), rsp_rdata=captured rdata (write: 0), rsp_resp=captured resp.
REQ-026 IDLE may accept a new request in the same cycle rsp_valid pulses.
REQ-027 Minimum latency, zero-wait subordinate: accept cycle 0, valids cycle 1, ready/resp handshake cycle 2, rsp_valid cycle 3.
REQ-028 m_awprot, m_arprot constant 3'b000; m_bready/m_rready asserted only in WRESP/RRESP.
REQ-029 AXI outputs registered; m_*valid never deasserts before handshake; address/data stable while valid.
REQ-030 SLVERR/DECERR passed through unmodified on rsp_resp; no retry.

Reset
REQ-031 aresetn=0 asynchronously: state IDLE, rr_ptr=NUM_REQ-1, all valid/ready/rsp_valid outputs 0, busy 0, rsp_rdata 0, rsp_resp 2'b00, latched request cleared.
REQ-032 Reset mid-transaction abandons it; no rsp_valid for it after release; first grant after release goes to lowest-index valid requester.

Verification
REQ-033 Single write req0 addr 0x10 data 0xA5A5A5A5 strb 0xF, zero-wait sub -> m_awaddr 0x10 cycle 1, rsp_valid[0] cycle 3, rsp_resp 00.
REQ-034 req0,req1 both held valid after reset, 4 transactions each -> grants alternate 0,1,0,1,...; never two consecutive to one requester.
REQ-035 Write with m_wready 3 cycles before m_awready, then m_bvalid delayed 5 cycles -> m_wvalid drops first, m_awvalid held, single rsp_valid after B.
REQ-036 Read req1 addr 0x20, sub returns rdata 0x12345678 rresp 10 -> rsp_valid[1] one cycle, rsp_rdata 0x12345678, rsp_resp 10.
REQ-037 aresetn low during WRESP -> all m_*valid/ready 0 immediately, busy 0, no stale rsp_valid after release.
REQ-038 Back-to-back requests -> new req_ready coincides with prior rsp_valid cycle; protocol checker shows no AXI4-Lite violations.
